duty_button_conditioner: RTL and testbench

- Upstream stage of the PWM duty controller. Conditions the two raw push-button inputs (increase and decrease).
- Per button: 2-flop synchronizer, then debouncer, then press-edge detector with optional auto-repeat.
- Emits single-cycle inc_pulse / dec_pulse. The PWM stage steps duty exactly once per pulse, not once per clock while a button is held.

---
 rtl/duty_button_conditioner.sv | 193 +++++++++++++++++++
 tb/tb_duty_button_conditioner.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/duty_button_conditioner.sv
// Push-button conditioner for the PWM duty controller.
// Each button passes through a 2-flop synchronizer, a counting debouncer
// and a press/auto-repeat pulse generator. Pulses are suppressed while
// both buttons are held at once.

module duty_button_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_ENABLE   = 1,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic pulse_o,
  output logic held_o
);

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RPT  = 2'd2
  } state_t;

  logic [1:0]       sync_q;
  logic             sync_s;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic             pulse_q, pulse_d;

  assign sync_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous raw button.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
    end
  end

  // Debouncer: accept a new level only after it has held for the full count.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    if (sync_s == deb_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DEB_LAST) begin
      deb_d  = sync_s;
      dcnt_d = '0;
    end else begin
      dcnt_d = dcnt_q + CNT_ONE;
    end
  end

  // Debouncer state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      deb_q  <= 1'b0;
      dcnt_q <= '0;
    end else begin
      deb_q  <= deb_d;
      dcnt_q <= dcnt_d;
    end
  end

  // Pulse FSM next state. It looks at the level being loaded this edge
  // (deb_d) so the first pulse coincides with the held level rising and
  // no pulse can be issued on the edge where the level falls.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pulse_d = 1'b0;
    if (!deb_d) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!deb_q) begin
            pulse_d = 1'b1;
            tmr_d   = '0;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Without auto-repeat the channel parks here until release.
          if (REPEAT_ENABLE != 0) begin
            if (tmr_q == DELAY_LAST) begin
              pulse_d = 1'b1;
              tmr_d   = '0;
              state_d = ST_RPT;
            end else begin
              tmr_d = tmr_q + CNT_ONE;
            end
          end
        end
        ST_RPT: begin
          if (tmr_q == PERIOD_LAST) begin
            pulse_d = 1'b1;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end
      endcase
    end
  end

  // Pulse FSM state, timer and registered pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;
  assign held_o  = deb_q;

endmodule

module duty_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_ENABLE   = 1,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic inc_held,
  output logic dec_held
);

  logic inc_p, dec_p;
  logic both_held;

  duty_button_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_ENABLE   (REPEAT_ENABLE),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .CNT_W           (CNT_W)
  ) u_inc (
    .clk_i   (clk),
    .rst_i   (rst),
    .raw_i   (btn_inc_raw),
    .pulse_o (inc_p),
    .held_o  (inc_held)
  );

  duty_button_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_ENABLE   (REPEAT_ENABLE),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .CNT_W           (CNT_W)
  ) u_dec (
    .clk_i   (clk),
    .rst_i   (rst),
    .raw_i   (btn_dec_raw),
    .pulse_o (dec_p),
    .held_o  (dec_held)
  );

  // Both buttons down is ambiguous: mask pulses but let the timers run on.
  assign both_held = inc_held & dec_held;
  assign inc_pulse = inc_p & ~both_held;
  assign dec_pulse = dec_p & ~both_held;

endmodule

// File: tb/tb_duty_button_conditioner.sv
// Bench for duty_button_conditioner: one repeating and one single-shot
// instance share the same button stimulus and are checked every cycle
// against an event-count model, plus directed literal expectations.

module tb_duty_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 4;

  logic clk = 1'b0;
  logic rst;
  logic inc_raw, dec_raw;
  logic r_inc_p, r_dec_p, r_inc_h, r_dec_h;
  logic o_inc_p, o_dec_p, o_inc_h, o_dec_h;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  duty_button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_ENABLE   (1),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .CNT_W           (16)
  ) u_rep (
    .clk         (clk),
    .rst         (rst),
    .btn_inc_raw (inc_raw),
    .btn_dec_raw (dec_raw),
    .inc_pulse   (r_inc_p),
    .dec_pulse   (r_dec_p),
    .inc_held    (r_inc_h),
    .dec_held    (r_dec_h)
  );

  duty_button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_ENABLE   (0),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .CNT_W           (16)
  ) u_one (
    .clk         (clk),
    .rst         (rst),
    .btn_inc_raw (inc_raw),
    .btn_dec_raw (dec_raw),
    .inc_pulse   (o_inc_p),
    .dec_pulse   (o_dec_p),
    .inc_held    (o_inc_h),
    .dec_held    (o_dec_h)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_n(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the raw sample seen two edges ago is the observed
  // level; a level change is accepted after D consecutive disagreeing
  // observations; pulses fall on hold ages 0, RD, RD+RP, RD+2RP, ...
  logic [1:0] m_hist [2];
  bit  m_lvl  [2];
  int  m_run  [2];
  int  m_age  [2];
  bit  m_prep [2];
  bit  m_pone [2];
  bit  m_valid = 1'b0;

  always @(posedge clk) begin
    bit raw_v [2];
    raw_v[0] = inc_raw;
    raw_v[1] = dec_raw;
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        m_hist[c] = 2'b00;
        m_lvl[c]  = 1'b0;
        m_run[c]  = 0;
        m_age[c]  = 0;
        m_prep[c] = 1'b0;
        m_pone[c] = 1'b0;
      end else begin
        bit obs;
        bit was;
        obs = m_hist[c][1];
        m_hist[c] = {m_hist[c][0], raw_v[c]};
        was = m_lvl[c];
        if (obs != m_lvl[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == D) begin
            m_lvl[c] = obs;
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        if (m_lvl[c] && !was) m_age[c] = 0;
        else if (m_lvl[c]) m_age[c] = m_age[c] + 1;
        m_pone[c] = m_lvl[c] && !was;
        m_prep[c] = m_pone[c] ||
                    (m_lvl[c] && m_age[c] >= RD && ((m_age[c] - RD) % RP) == 0);
      end
    end
    if (rst) m_valid = 1'b1;
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      bit both;
      both = m_lvl[0] & m_lvl[1];
      chk("rep.inc_held",  r_inc_h, m_lvl[0]);
      chk("rep.dec_held",  r_dec_h, m_lvl[1]);
      chk("rep.inc_pulse", r_inc_p, m_prep[0] & ~both);
      chk("rep.dec_pulse", r_dec_p, m_prep[1] & ~both);
      chk("one.inc_held",  o_inc_h, m_lvl[0]);
      chk("one.dec_held",  o_dec_h, m_lvl[1]);
      chk("one.inc_pulse", o_inc_p, m_pone[0] & ~both);
      chk("one.dec_pulse", o_dec_p, m_pone[1] & ~both);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int n2;
    int rem [2];
    bit lvl [2];
    int bounce [11];

    rst = 1'b1; inc_raw = 1'b0; dec_raw = 1'b0;
    repeat (3) tick();
    chk("reset inc_held",  r_inc_h, 1'b0);
    chk("reset dec_held",  r_dec_h, 1'b0);
    chk("reset inc_pulse", r_inc_p, 1'b0);
    chk("reset dec_pulse", r_dec_p, 1'b0);
    rst = 1'b0;
    tick();
    chk("post-reset inc_pulse", r_inc_p, 1'b0);
    repeat (4) tick();

    // Clean press: first sampled on the next edge (k); rise at k+5.
    inc_raw = 1'b1;
    repeat (5) tick();
    chk("press k+4 inc_held",  r_inc_h, 1'b0);
    chk("press k+4 inc_pulse", r_inc_p, 1'b0);
    tick();
    chk("press k+5 inc_held",  r_inc_h, 1'b1);
    chk("press k+5 inc_pulse", r_inc_p, 1'b1);
    chk("press k+5 one pulse", o_inc_p, 1'b1);
    chk("press k+5 dec_pulse", r_dec_p, 1'b0);
    tick();
    chk("press k+6 inc_pulse", r_inc_p, 1'b0);
    repeat (6) tick();
    chk("press k+12 inc_pulse", r_inc_p, 1'b0);
    tick();
    chk("press k+13 inc_pulse", r_inc_p, 1'b1);
    chk("press k+13 one pulse", o_inc_p, 1'b0);
    repeat (4) tick();
    chk("press k+17 inc_pulse", r_inc_p, 1'b1);
    repeat (22) tick();
    inc_raw = 1'b0;
    repeat (5) tick();
    chk("release k+4 inc_held", r_inc_h, 1'b1);
    tick();
    chk("release k+5 inc_held", r_inc_h, 1'b0);
    repeat (10) tick();

    // Glitch: 3 cycles high must be invisible.
    n = 0;
    inc_raw = 1'b1;
    repeat (3) begin tick(); if (r_inc_h | r_inc_p) n++; end
    inc_raw = 1'b0;
    repeat (15) begin tick(); if (r_inc_h | r_inc_p) n++; end
    chk_n("glitch activity", n, 0);

    // Bounce: short runs then a steady run of 6 -> one pulse only.
    bounce = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1};
    n = 0;
    for (int i = 0; i < 11; i++) begin
      dec_raw = bounce[i];
      tick();
      if (r_dec_p) n++;
    end
    dec_raw = 1'b0;
    repeat (20) begin tick(); if (r_dec_p) n++; end
    chk_n("bounce dec pulses", n, 1);

    // Conflict: inc held, dec joins for 30 cycles.
    inc_raw = 1'b1;
    repeat (10) tick();
    dec_raw = 1'b1;
    n = 0;
    repeat (30) begin tick(); if (r_inc_h & r_dec_h & (r_inc_p | r_dec_p)) n++; end
    chk_n("conflict pulses", n, 0);
    dec_raw = 1'b0;
    n2 = 0;
    repeat (20) begin tick(); if (r_inc_p) n2++; end
    chk("conflict resume", n2 > 0, 1'b1);
    inc_raw = 1'b0;
    repeat (20) tick();

    // Single-shot instance: 100-cycle hold gives exactly one pulse.
    n = 0;
    inc_raw = 1'b1;
    repeat (100) begin tick(); if (o_inc_p) n++; end
    inc_raw = 1'b0;
    repeat (20) begin tick(); if (o_inc_p) n++; end
    chk_n("no-repeat pulses", n, 1);

    // Reset mid-hold.
    inc_raw = 1'b1;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    chk("midrst inc_held",  r_inc_h, 1'b0);
    chk("midrst inc_pulse", r_inc_p, 1'b0);
    tick();
    chk("midrst dec_held",  r_dec_h, 1'b0);
    chk("midrst dec_pulse", r_dec_p, 1'b0);
    rst = 1'b0;
    repeat (5) tick();
    chk("midrst k+4 inc_pulse", r_inc_p, 1'b0);
    tick();
    chk("midrst k+5 inc_pulse", r_inc_p, 1'b1);
    chk("midrst k+5 inc_held",  r_inc_h, 1'b1);
    inc_raw = 1'b0;
    repeat (20) tick();

    // Randomized runs of varying length, with occasional resets.
    rem[0] = 0; rem[1] = 0; lvl[0] = 1'b0; lvl[1] = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if (rem[c] == 0) begin
          lvl[c] = ~lvl[c];
          if ($urandom_range(0, 3) == 0) rem[c] = $urandom_range(20, 60);
          else rem[c] = $urandom_range(1, 8);
        end
        rem[c]--;
      end
      inc_raw = lvl[0];
      dec_raw = lvl[1];
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;
    inc_raw = 1'b0;
    dec_raw = 1'b0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
